// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// A queued load is carried as a wb_entry {live, dest, data}.
package wb_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] REG0  = 4'd0;
  localparam logic [ADDR_W-1:0] REG_T = 4'd15;

  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry;

  // True when the entry is still going to write register r.
  function automatic logic regHit(input wb_entry e, input logic [ADDR_W-1:0] r);
    return e.live && (e.dest == r);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO with per-entry kill by destination register.
// Popped and killed slots have their live bit cleared, so LiveVec only flags pending writes.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Push,
  input  wb_entry                      PushEntry,
  input  logic                         Pop,
  input  logic                         KillEn,
  input  logic [ADDR_W-1:0]            KillReg,
  output logic                         Full,
  output logic                         Empty,
  output wb_entry                      Head,
  output logic [DEPTH-1:0]             LiveVec,
  output logic [DEPTH-1:0][ADDR_W-1:0] RegVec
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry          memR [DEPTH];
  logic [PTR_W-1:0] wrPtrR;
  logic [PTR_W-1:0] rdPtrR;
  logic [PTR_W:0]   countR;
  logic             pushOk;
  logic             popOk;

  assign Full   = (countR == (PTR_W + 1)'(DEPTH));
  assign Empty  = (countR == '0);
  assign pushOk = Push && !Full;
  assign popOk  = Pop && !Empty;
  assign Head   = memR[rdPtrR];

  // Expose live/dest of every slot for busy lookup.
  always_comb begin
    LiveVec = '0;
    RegVec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      LiveVec[i] = memR[i].live;
      RegVec[i]  = memR[i].dest;
    end
  end

  // Storage, pointers and occupancy; a same-cycle push overrides any kill on its slot.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        memR[i] <= '0;
      end
      wrPtrR <= '0;
      rdPtrR <= '0;
      countR <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (KillEn && regHit(memR[i], KillReg)) begin
          memR[i].live <= 1'b0;
        end
      end
      if (popOk) begin
        memR[rdPtrR].live <= 1'b0;
        rdPtrR            <= rdPtrR + PTR_W'(1);
      end
      if (pushOk) begin
        memR[wrPtrR] <= PushEntry;
        wrPtrR       <= wrPtrR + PTR_W'(1);
      end
      case ({pushOk, popOk})
        2'b10:   countR <= countR + (PTR_W + 1)'(1);
        2'b01:   countR <= countR - (PTR_W + 1)'(1);
        default: countR <= countR;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and buffered load results into one
// registered register-file write port, with per-register busy flags for decode.
module wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluReg,
  input  logic [DATA_W-1:0] AluData,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [ADDR_W-1:0] MemReg,
  input  logic [DATA_W-1:0] MemData,
  output logic              RegWre,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rt,
  output logic              RsBusy,
  output logic              RtBusy
);

  import wb_arbiter_pkg::*;

  logic                         readyR;
  logic                         fifoFull;
  logic                         fifoEmpty;
  logic                         pushS;
  logic                         popS;
  logic                         killEnS;
  wb_entry                      pushEntryS;
  wb_entry                      headS;
  logic [DEPTH-1:0]             liveVecS;
  logic [DEPTH-1:0][ADDR_W-1:0] regVecS;
  logic                         wreS;
  logic [ADDR_W-1:0]            selRegS;
  logic [DATA_W-1:0]            selDataS;

  // A register is busy when some queued, not-yet-killed load still targets it.
  function automatic logic regBusy(
    input logic [ADDR_W-1:0]            r,
    input logic [DEPTH-1:0]             live,
    input logic [DEPTH-1:0][ADDR_W-1:0] regs
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (regs[i] == r)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return (r != REG0) && hit;
  endfunction

  // Holds MemReady low through reset and for the edge that releases it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      readyR <= 1'b0;
    end else begin
      readyR <= 1'b1;
    end
  end

  assign MemReady   = readyR && !fifoFull;
  assign pushS      = MemValid && MemReady;
  assign popS       = !AluValid && !fifoEmpty;
  assign killEnS    = AluValid && (AluReg != REG0);
  assign pushEntryS = '{live: 1'b1, dest: MemReg, data: MemData};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) uFifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .Push      (pushS),
    .PushEntry (pushEntryS),
    .Pop       (popS),
    .KillEn    (killEnS),
    .KillReg   (AluReg),
    .Full      (fifoFull),
    .Empty     (fifoEmpty),
    .Head      (headS),
    .LiveVec   (liveVecS),
    .RegVec    (regVecS)
  );

  // Source selection: ALU first, else drain the FIFO head; register 0 never writes.
  always_comb begin
    wreS     = 1'b0;
    selRegS  = AluReg;
    selDataS = AluData;
    if (AluValid) begin
      wreS     = (AluReg != REG0);
      selRegS  = AluReg;
      selDataS = AluData;
    end else if (!fifoEmpty) begin
      wreS     = headS.live && (headS.dest != REG0);
      selRegS  = headS.dest;
      selDataS = headS.data;
    end else begin
      wreS     = 1'b0;
      selRegS  = WriteReg;
      selDataS = WriteData;
    end
  end

  // Registered write port; address and data hold while no write is issued.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RegWre    <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      RegWre <= wreS;
      if (wreS) begin
        WriteReg  <= selRegS;
        WriteData <= selDataS;
      end else begin
        WriteReg  <= WriteReg;
        WriteData <= WriteData;
      end
    end
  end

  assign RsBusy = regBusy(Rs, liveVecS, regVecS);
  assign RtBusy = regBusy(Rt, liveVecS, regVecS);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: table-driven vectors with a write-port
// scoreboard, plus hand-built backpressure and mid-operation reset sequences.
module tb_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        AluValid, MemValid, MemReady, RegWre, RsBusy, RtBusy;
  logic [3:0]  AluReg, MemReg, WriteReg, Rs, Rt;
  logic [15:0] AluData, MemData, WriteData;

  always #5 Clk = ~Clk;

  wb_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
    .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
    .Rs(Rs), .Rt(Rt), .RsBusy(RsBusy), .RtBusy(RtBusy)
  );

  typedef struct {
    logic av; logic [3:0] ar; logic [15:0] ad;
    logic mv; logic [3:0] mr; logic [15:0] md;
    logic [3:0] rs; logic [3:0] rt;
    logic eRsBusy; logic eRtBusy; logic eReady;
    logic eWre; logic [3:0] eReg; logic [15:0] eData;
  } vec_t;

  typedef struct { logic wre; logic [3:0] rg; logic [15:0] data; } exp_t;

  exp_t expQ[$];
  vec_t tbl[17];
  int   checks = 0;
  int   passed = 0;

  function automatic vec_t mk(
    input logic av, input logic [3:0] ar, input logic [15:0] ad,
    input logic mv, input logic [3:0] mr, input logic [15:0] md,
    input logic [3:0] rs, input logic [3:0] rt,
    input logic eS, input logic eT, input logic eRdy,
    input logic eW, input logic [3:0] eR, input logic [15:0] eD);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.rs = rs; v.rt = rt; v.eRsBusy = eS; v.eRtBusy = eT; v.eReady = eRdy;
    v.eWre = eW; v.eReg = eR; v.eData = eD;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of stimulus, check combinational outputs, then the registered write.
  task automatic applyVec(input vec_t v, input string tag);
    exp_t e;
    AluValid = v.av; AluReg = v.ar; AluData = v.ad;
    MemValid = v.mv; MemReg = v.mr; MemData = v.md;
    Rs = v.rs; Rt = v.rt;
    #1;
    check({tag, ".RsBusy"}, RsBusy, v.eRsBusy);
    check({tag, ".RtBusy"}, RtBusy, v.eRtBusy);
    check({tag, ".MemReady"}, MemReady, v.eReady);
    e.wre = v.eWre; e.rg = v.eReg; e.data = v.eData;
    expQ.push_back(e);
    @(posedge Clk);
    #1;
    e = expQ.pop_front();
    check({tag, ".RegWre"}, RegWre, e.wre);
    check({tag, ".WriteReg"}, WriteReg, e.rg);
    check({tag, ".WriteData"}, WriteData, e.data);
  endtask

  initial begin
    // ALU issue, load drain, kill, same-cycle push vs ALU, register 0, flag register
    tbl[0]  = mk(1'b1, 4'd3, 16'h00A5, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 16'h00A5);
    tbl[1]  = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'h00A5);
    tbl[2]  = mk(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h1111, 4'd5, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'h00A5);
    tbl[3]  = mk(1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 16'h2222, 4'd5, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 16'h1111);
    tbl[4]  = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd6, 1'b0, 1'b1, 1'b1, 1'b1, 4'd6, 16'h2222);
    tbl[5]  = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd6, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 16'h2222);
    tbl[6]  = mk(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'hBEEF, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 16'h2222);
    tbl[7]  = mk(1'b1, 4'd7, 16'h0001, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 16'h0001);
    tbl[8]  = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 16'h0001);
    tbl[9]  = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 16'h0001);
    tbl[10] = mk(1'b1, 4'd8, 16'h00AA, 1'b1, 4'd8, 16'h0BBB, 4'd8, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 16'h00AA);
    tbl[11] = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd8, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 4'd8, 16'h0BBB);
    tbl[12] = mk(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h1234, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 16'h0BBB);
    tbl[13] = mk(1'b1, 4'd0, 16'h5678, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 16'h0BBB);
    tbl[14] = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 16'h0BBB);
    tbl[15] = mk(1'b1, 4'd15, 16'h8001, 1'b0, 4'd0, 16'h0000, 4'd15, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 16'h8001);
    tbl[16] = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd15, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 16'h8001);

    AluValid = 1'b0; AluReg = 4'd0; AluData = 16'h0000;
    MemValid = 1'b0; MemReg = 4'd0; MemData = 16'h0000;
    Rs = 4'd0; Rt = 4'd0;
    Rst = 1'b0;
    #2 Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset.RegWre", RegWre, 1'b0);
    check("reset.WriteReg", WriteReg, 4'd0);
    check("reset.WriteData", WriteData, 16'h0000);
    check("reset.MemReady", MemReady, 1'b0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check("release.MemReady", MemReady, 1'b1);

    for (int i = 0; i < 17; i++) applyVec(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure: ALU held 6 cycles while 5 loads are offered; FIFO fills at 4.
    for (int k = 0; k < 12; k++) begin
      vec_t v;
      int   li;
      li = (k < 4) ? k : 4;
      v.av = (k < 6); v.ar = 4'd1; v.ad = 16'h0100 + 16'(k);
      v.mv = (k < 8); v.mr = 4'd9 + 4'(li); v.md = 16'hA000 + 16'(li);
      v.rs = 4'd9; v.rt = 4'd13;
      v.eReady  = (k < 4) || (k >= 7);
      v.eRsBusy = (k >= 1) && (k <= 6);
      v.eRtBusy = (k >= 8) && (k <= 10);
      if (k < 6) begin
        v.eWre = 1'b1; v.eReg = 4'd1; v.eData = 16'h0100 + 16'(k);
      end else if (k < 11) begin
        v.eWre = 1'b1; v.eReg = 4'd9 + 4'(k - 6); v.eData = 16'hA000 + 16'(k - 6);
      end else begin
        v.eWre = 1'b0; v.eReg = 4'd13; v.eData = 16'hA004;
      end
      applyVec(v, $sformatf("full%0d", k));
    end

    // Reset with three queued loads and a write on the port.
    for (int k = 0; k < 3; k++) begin
      applyVec(mk(1'b1, 4'd2, 16'h0200 + 16'(k), 1'b1, 4'd4 + 4'(k), 16'hC000 + 16'(k),
                  4'd4, 4'd5, (k > 0), (k > 1), 1'b1, 1'b1, 4'd2, 16'h0200 + 16'(k)),
               $sformatf("prerst%0d", k));
    end
    AluValid = 1'b0; MemValid = 1'b0; Rs = 4'd4; Rt = 4'd5;
    Rst = 1'b1;
    #1;
    check("midrst.RegWre", RegWre, 1'b0);
    check("midrst.WriteReg", WriteReg, 4'd0);
    check("midrst.WriteData", WriteData, 16'h0000);
    check("midrst.MemReady", MemReady, 1'b0);
    check("midrst.RsBusy", RsBusy, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      applyVec(mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd4, 4'd5,
                  1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000), $sformatf("postrst%0d", k));
    end

    check("scoreboard_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter that sits on the write side of the 16x16 register file.
- Merges single-cycle ALU results with variable-latency memory load results into one registered write port: RegWre, WriteReg, WriteData.
- Buffers load results in a small FIFO and reports per-register busy status so decode can stall on pending loads.
- Resolves write-after-write ordering between the two sources.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 4, register address width (16 registers).
- DEPTH, 4, load-result FIFO entries; power of two, at least 2.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Rst  input  1  asynchronous, active-high reset.
- AluValid  input  1  ALU result valid this cycle; always accepted, no backpressure.
- AluReg  input  ADDR_W  ALU destination register.
- AluData  input  DATA_W  ALU result.
- MemValid  input  1  load result offered.
- MemReady  output  1  load result accepted when MemValid && MemReady.
- MemReg  input  ADDR_W  load destination register.
- MemData  input  DATA_W  load data.
- RegWre  output  1  register-file write enable.
- WriteReg  output  ADDR_W  register-file write address.
- WriteData  output  DATA_W  register-file write data.
- Rs  input  ADDR_W  decode source register 1.
- Rt  input  ADDR_W  decode source register 2.
- RsBusy  output  1  a live queued load targets Rs.
- RtBusy  output  1  a live queued load targets Rt.

Behaviour:
- Reset (asynchronous, Rst=1):
  - RegWre=0, WriteReg=0, WriteData=0.
  - FIFO empty, all kill bits cleared.
  - MemReady=0 while Rst is high; MemReady=1 on the first cycle after release.
- Reset mid-operation: all queued loads are discarded and no write is issued for them. An in-flight RegWre drops immediately.
- Output stage is registered; each write appears on the write port one cycle after selection.
- Per-cycle selection:
  - If AluValid, the ALU result is issued.
  - Else, if the FIFO head is present, the head is popped and issued (RegWre=1 only if the head is live).
  - Else RegWre=0.
  - WriteReg and WriteData hold their last value when RegWre=0.
- Register 0: a write to register 0 from either source is consumed but yields RegWre=0.
- T register: data passes through unmodified. Flag conversion belongs to the register file.
- MemReady is !full, computed from registered state only.
  - No push is accepted when full, even if a pop occurs in the same cycle.
  - When not full, a push and a pop in the same cycle leave the occupancy unchanged.
- WAW ordering: the ALU result is always newer than any queued load.
  - When AluValid, every live FIFO entry with reg==AluReg (AluReg!=0) is killed the same cycle.
  - A killed entry still occupies a slot and is popped in order with RegWre=0.
  - A load pushed in the same cycle as an ALU write to the same register is not killed; it is newer.
- Busy flags are combinational from the current FIFO state:
  - RsBusy = (Rs!=0) && any live entry has reg==Rs. RtBusy is defined the same way.
  - Killed entries never assert busy.
  - The entry being popped this cycle still asserts busy, because its write lands at the next edge.
- Starvation: loads may wait indefinitely under back-to-back AluValid. This is acceptable; decode stalls on busy.
- Occupancy counter: ADDR width is log2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W, REG0 (0), REG_T (the flag register index).
  - The wb_entry typedef {live, reg, data}.
- Natural sub-module: wb_fifo. It is a synchronous FIFO with:
  - per-entry kill by register match;
  - a push/pop/full/empty interface;
  - a per-entry live/reg vector for busy lookup.
- The arbiter top contains selection, the output register, and busy reduction.

Test Plan:
- Reset then AluValid, AluReg=3, AluData=16'h00A5 -> next cycle RegWre=1, WriteReg=3, WriteData=16'h00A5. Following cycle RegWre=0.
- Push loads (5,16'h1111), (6,16'h2222) with no ALU traffic -> writes to reg 5 then reg 6 on consecutive cycles. RsBusy=1 with Rs=5 until the reg 5 pop cycle.
- Queue load (7,16'hBEEF), then AluValid (7,16'h0001) before the pop -> reg 7 written with 16'h0001 only. The later pop gives RegWre=0 and RsBusy(Rs=7) drops at the kill.
- Hold AluValid while pushing 4 loads -> MemReady=0 after the 4th push. The 5th load is held until the ALU stops, then all drain in FIFO order.
- Load to reg 0 and ALU write to reg 0 -> both consumed with RegWre=0. RsBusy(Rs=0)=0 throughout.
- Assert Rst with 3 queued loads and RegWre=1 -> RegWre=0 immediately and MemReady=0. After release the FIFO is empty and no writes occur.
